// File: rtl/vliw_pkg.sv
// Shared types for the VLIW core writeback path.
package vliw_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        WB_LSU  = 2'd0,
        WB_IXU1 = 2'd1,
        WB_IXU2 = 2'd2
    } wb_slot_e;

    localparam int unsigned NUM_WB_PORTS = 3;

endpackage

// File: rtl/wb_slot.sv
// One writeback holding entry: accepts a result through valid/ready and
// keeps it until it retires; wb_hold freezes the entry in place.
module wb_slot
    import vliw_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     res_valid,
    input  reg_idx_t res_rd,
    input  word_t    res_data,
    input  logic     wb_hold,
    output logic     res_ready,
    output logic     ent_valid,
    output reg_idx_t ent_rd,
    output word_t    ent_data
);

    logic     valid_q, valid_d;
    reg_idx_t rd_q, rd_d;
    word_t    data_q, data_d;
    logic     load;

    // A valid entry drains every non-held cycle, so it can be refilled at once.
    assign res_ready = !valid_q || !wb_hold;
    assign load      = res_valid && res_ready;

    // Next-state: load wins, otherwise drain unless held.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            rd_d    = res_rd;
            data_d  = res_data;
        end else if (!wb_hold) begin
            valid_d = 1'b0;
        end
    end

    // Entry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign ent_valid = valid_q;
    assign ent_rd    = rd_q;
    assign ent_data  = data_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: three holding entries, same-rd conflict resolution
// (IXU2 > IXU1 > LSU) and a per-register pending-write scoreboard.
// Optional feature: define WB_CONFLICT_CNT_EN to add the conflict_cnt port.
module writeback_unit
    import vliw_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lsu_res_valid,
    output logic                lsu_res_ready,
    input  reg_idx_t            lsu_res_rd,
    input  word_t               lsu_res_data,
    input  logic                ixu1_res_valid,
    output logic                ixu1_res_ready,
    input  reg_idx_t            ixu1_res_rd,
    input  word_t               ixu1_res_data,
    input  logic                ixu2_res_valid,
    output logic                ixu2_res_ready,
    input  reg_idx_t            ixu2_res_rd,
    input  word_t               ixu2_res_data,
    input  logic                iss_lsu_en,
    input  reg_idx_t            iss_lsu_rd,
    input  logic                iss_ixu1_en,
    input  reg_idx_t            iss_ixu1_rd,
    input  logic                iss_ixu2_en,
    input  reg_idx_t            iss_ixu2_rd,
    input  logic                wb_hold,
    output logic                lsu_wr_en,
    output reg_idx_t            lsu_rd,
    output word_t               lsu_wr_data,
    output logic                ixu1_wr_en,
    output reg_idx_t            ixu1_rd,
    output word_t               ixu1_wr_data,
    output logic                ixu2_wr_en,
    output reg_idx_t            ixu2_rd,
    output word_t               ixu2_wr_data,
    output logic [NUM_REGS-1:0] pend_busy,
    output logic [NUM_REGS-1:0] pend_full
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [15:0]         conflict_cnt
`endif
);

    localparam logic signed [CNT_W+1:0] One    = {{(CNT_W + 1){1'b0}}, 1'b1};
    localparam logic signed [CNT_W+1:0] CntMax = {2'b00, {CNT_W{1'b1}}};

    logic [NUM_WB_PORTS-1:0] res_valid_v, res_ready_v, ent_valid, retire, wr_en_v, iss_en_v;
    reg_idx_t                res_rd_v [NUM_WB_PORTS];
    word_t                   res_data_v [NUM_WB_PORTS];
    reg_idx_t                ent_rd [NUM_WB_PORTS];
    word_t                   ent_data [NUM_WB_PORTS];
    reg_idx_t                iss_rd_v [NUM_WB_PORTS];
    logic                    lose_lsu, lose_ixu1;

    logic [CNT_W-1:0]        cnt_q [NUM_REGS];
    logic [CNT_W-1:0]        cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0]     busy_q, busy_d, full_q, full_d;
    logic signed [CNT_W+1:0] acc;

    assign res_valid_v = {ixu2_res_valid, ixu1_res_valid, lsu_res_valid};
    assign iss_en_v    = {iss_ixu2_en, iss_ixu1_en, iss_lsu_en};

    assign res_rd_v[WB_LSU]    = lsu_res_rd;
    assign res_rd_v[WB_IXU1]   = ixu1_res_rd;
    assign res_rd_v[WB_IXU2]   = ixu2_res_rd;
    assign res_data_v[WB_LSU]  = lsu_res_data;
    assign res_data_v[WB_IXU1] = ixu1_res_data;
    assign res_data_v[WB_IXU2] = ixu2_res_data;
    assign iss_rd_v[WB_LSU]    = iss_lsu_rd;
    assign iss_rd_v[WB_IXU1]   = iss_ixu1_rd;
    assign iss_rd_v[WB_IXU2]   = iss_ixu2_rd;

    for (genvar g = 0; g < NUM_WB_PORTS; g++) begin : g_slot
        wb_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .res_valid (res_valid_v[g]),
            .res_rd    (res_rd_v[g]),
            .res_data  (res_data_v[g]),
            .wb_hold   (wb_hold),
            .res_ready (res_ready_v[g]),
            .ent_valid (ent_valid[g]),
            .ent_rd    (ent_rd[g]),
            .ent_data  (ent_data[g])
        );
    end

    assign lsu_res_ready  = res_ready_v[WB_LSU];
    assign ixu1_res_ready = res_ready_v[WB_IXU1];
    assign ixu2_res_ready = res_ready_v[WB_IXU2];

    // Commit: later bundle slot wins a same-rd collision; rd 0 never writes.
    always_comb begin
        retire    = ent_valid & {NUM_WB_PORTS{!wb_hold}};
        lose_ixu1 = retire[WB_IXU1] && (ent_rd[WB_IXU1] != '0) &&
                    retire[WB_IXU2] && (ent_rd[WB_IXU2] == ent_rd[WB_IXU1]);
        lose_lsu  = retire[WB_LSU] && (ent_rd[WB_LSU] != '0) &&
                    ((retire[WB_IXU1] && (ent_rd[WB_IXU1] == ent_rd[WB_LSU])) ||
                     (retire[WB_IXU2] && (ent_rd[WB_IXU2] == ent_rd[WB_LSU])));
        wr_en_v[WB_IXU2] = retire[WB_IXU2] && (ent_rd[WB_IXU2] != '0);
        wr_en_v[WB_IXU1] = retire[WB_IXU1] && (ent_rd[WB_IXU1] != '0) && !lose_ixu1;
        wr_en_v[WB_LSU]  = retire[WB_LSU] && (ent_rd[WB_LSU] != '0) && !lose_lsu;
    end

    assign lsu_wr_en    = wr_en_v[WB_LSU];
    assign lsu_rd       = ent_rd[WB_LSU];
    assign lsu_wr_data  = ent_data[WB_LSU];
    assign ixu1_wr_en   = wr_en_v[WB_IXU1];
    assign ixu1_rd      = ent_rd[WB_IXU1];
    assign ixu1_wr_data = ent_data[WB_IXU1];
    assign ixu2_wr_en   = wr_en_v[WB_IXU2];
    assign ixu2_rd      = ent_rd[WB_IXU2];
    assign ixu2_wr_data = ent_data[WB_IXU2];

    // Scoreboard next-state: count + issues - retirements, clamped; losers still retire.
    always_comb begin
        acc    = '0;
        busy_d = '0;
        full_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            acc = {2'b00, cnt_q[r]};
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                if (iss_en_v[p] && (iss_rd_v[p] == reg_idx_t'(r))) acc = acc + One;
                if (retire[p] && (ent_rd[p] == reg_idx_t'(r)))     acc = acc - One;
            end
            if (r == 0)              cnt_d[r] = '0;
            else if (acc[CNT_W+1])   cnt_d[r] = '0;
            else if (acc > CntMax)   cnt_d[r] = CntMax[CNT_W-1:0];
            else                     cnt_d[r] = acc[CNT_W-1:0];
            busy_d[r] = (cnt_d[r] != '0);
            full_d[r] = (cnt_d[r] == '1);
        end
    end

    // Scoreboard counters and their registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            busy_q <= '0;
            full_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            busy_q <= busy_d;
            full_q <= full_d;
        end
    end

    assign pend_busy = busy_q;
    assign pend_full = full_q;

`ifdef WB_CONFLICT_CNT_EN
    logic [1:0]  drop_cnt;
    logic [16:0] conflict_sum;
    logic [15:0] conflict_q, conflict_d;

    // Saturating count of writes dropped by conflict resolution.
    always_comb begin
        drop_cnt     = {1'b0, lose_lsu} + {1'b0, lose_ixu1};
        conflict_sum = {1'b0, conflict_q} + {15'd0, drop_cnt};
        conflict_d   = conflict_sum[16] ? 16'hFFFF : conflict_sum[15:0];
    end

    // Conflict counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_q <= '0;
        else        conflict_q <= conflict_d;
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule
